// File: rtl/d_burst_wb.sv
// -----------------------------------------------------------------------------
// d_burst_wb -- cache line write-back burst engine
//
// Takes one dirty cache line (BEATS 32-bit words) from the cache and writes it
// to memory as a single burst: one address phase, BEATS data beats, then a
// wait for the write response. line_done pulses for one cycle when the
// response has been received.
//
// Ports:
//   clk         clock, all state on the rising edge
//   resetn      asynchronous active-low reset
//   line_valid  cache offers a dirty line (level-sensitive)
//   line_addr   line base address (low offset bits are dropped)
//   line_data   line contents, word k at [32k+31:32k]
//   line_ready  block is idle and takes the line this cycle
//   line_done   one-cycle pulse when the write-back has completed
//   mem_req     burst address request valid
//   mem_addr    burst base address
//   mem_addr_ok memory accepted the address
//   mem_wvalid  write beat valid
//   mem_wdata   write beat data
//   mem_wlast   final beat of the burst
//   mem_wready  memory accepted the beat
//   mem_bvalid  write response from memory
//   cnt         current beat index (debug)
// -----------------------------------------------------------------------------
module d_burst_wb #(
    parameter int BEATS = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  line_valid,
    input  logic [31:0]           line_addr,
    input  logic [32*BEATS-1:0]   line_data,
    output logic                  line_ready,
    output logic                  line_done,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_addr_ok,
    output logic                  mem_wvalid,
    output logic [31:0]           mem_wdata,
    output logic                  mem_wlast,
    input  logic                  mem_wready,
    input  logic                  mem_bvalid,
    output logic [3:0]            cnt
);

    localparam int          IW       = $clog2(BEATS);
    localparam logic [3:0]  LAST     = 4'(BEATS - 1);
    // Byte offset inside a line; these address bits are forced to zero.
    localparam logic [31:0] OFF_MASK = 32'(4 * BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_e;

    state_e                   state_q, state_d;
    logic [BEATS-1:0][31:0]   buf_q,   buf_d;
    logic [31:0]              addr_q,  addr_d;
    logic [3:0]               cnt_q,   cnt_d;
    logic                     done_q,  done_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            buf_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (line_valid) begin
                    buf_d   = line_data;
                    addr_d  = line_addr & ~OFF_MASK;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (mem_wready) begin
                    // cnt parks on the last index; it is only cleared by the
                    // next address acceptance.
                    if (cnt_q == LAST) begin
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            RESP: begin
                if (mem_bvalid) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from state so that reset clears them at once.
    assign line_ready = (state_q == IDLE);
    assign line_done  = done_q;
    assign mem_req    = (state_q == ADDR);
    assign mem_addr   = mem_req ? addr_q : '0;
    assign mem_wvalid = (state_q == DATA);
    assign mem_wdata  = mem_wvalid ? buf_q[cnt_q[IW-1:0]] : '0;
    assign mem_wlast  = mem_wvalid && (cnt_q == LAST);
    assign cnt        = cnt_q;

endmodule

// File: tb/tb_d_burst_wb.sv
module tb_d_burst_wb;

    localparam int BEATS = 8;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  line_valid;
    logic [31:0]           line_addr;
    logic [32*BEATS-1:0]   line_data;
    logic                  line_ready;
    logic                  line_done;
    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_addr_ok;
    logic                  mem_wvalid;
    logic [31:0]           mem_wdata;
    logic                  mem_wlast;
    logic                  mem_wready;
    logic                  mem_bvalid;
    logic [3:0]            cnt;

    d_burst_wb #(.BEATS(BEATS)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .line_valid  (line_valid),
        .line_addr   (line_addr),
        .line_data   (line_data),
        .line_ready  (line_ready),
        .line_done   (line_done),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_addr_ok (mem_addr_ok),
        .mem_wvalid  (mem_wvalid),
        .mem_wdata   (mem_wdata),
        .mem_wlast   (mem_wlast),
        .mem_wready  (mem_wready),
        .mem_bvalid  (mem_bvalid),
        .cnt         (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        last;
        int          idx;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_addr_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int outstanding = 0;
    int n_done = 0;
    int done_cyc = 0;
    int beats_fired = 0;
    int last_req_len = 0;

    // Responder knobs
    int addr_wait = 0;
    bit stall_en  = 0;
    bit stray_en  = 0;
    bit rand_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a line at address A with words W0..W(BEATS-1) becomes
    // one burst at A rounded down to the line size, the words in order, the
    // last one flagged, and exactly one completion.
    task automatic push_exp(input logic [31:0] a, input logic [32*BEATS-1:0] d);
        beat_t b;
        exp_addr_q.push_back(a & ~(32'(4 * BEATS) - 32'd1));
        for (int k = 0; k < BEATS; k++) begin
            b.d    = d[32*k +: 32];
            b.last = (k == BEATS - 1);
            b.idx  = k;
            exp_beats.push_back(b);
        end
        outstanding++;
    endtask

    // Memory-side responder: drives handshakes just after each rising edge.
    always begin : responder
        bit fire_w, wlast_fire, b_taken;
        bit b_pending;
        int beat_i, stall_cnt, req_cycles;
        b_pending = 0; beat_i = 0; stall_cnt = 0; req_cycles = 0;
        mem_addr_ok = 0; mem_wready = 0; mem_bvalid = 0;
        forever begin
            @(negedge clk);
            fire_w     = resetn && mem_wvalid && mem_wready;
            wlast_fire = fire_w && mem_wlast;
            b_taken    = resetn && mem_bvalid && b_pending;
            @(posedge clk);
            #1;
            if (b_taken) b_pending = 0;
            if (wlast_fire) b_pending = 1;
            if (fire_w) begin
                beat_i++;
                stall_cnt = 0;
            end
            if (!mem_wvalid) beat_i = 0;
            if (!resetn) begin
                b_pending = 0; beat_i = 0; stall_cnt = 0; req_cycles = 0;
            end

            if (mem_req) begin
                mem_addr_ok = rand_mode ? ($urandom_range(0, 2) == 0) : (req_cycles >= addr_wait);
                req_cycles++;
            end else begin
                req_cycles  = 0;
                mem_addr_ok = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            if (mem_wvalid) begin
                if (rand_mode) begin
                    mem_wready = ($urandom_range(0, 2) != 0);
                end else if (stall_en && (beat_i == 1 || beat_i == 5) && stall_cnt < 2) begin
                    mem_wready = 0;
                    stall_cnt++;
                end else begin
                    mem_wready = 1;
                end
            end else begin
                mem_wready = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            if (b_pending) mem_bvalid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            else           mem_bvalid = stray_en  ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor / scoreboard
    always begin : monitor
        bit          prev_req_wait, prev_stall, prev_done;
        logic [31:0] prev_addr, prev_wdata;
        logic [3:0]  prev_cnt;
        int          req_len;
        beat_t       b;
        logic [31:0] ea;
        prev_req_wait = 0; prev_stall = 0; prev_done = 0; req_len = 0;
        prev_addr = '0; prev_wdata = '0; prev_cnt = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_req_wait = 0; prev_stall = 0; prev_done = 0; req_len = 0;
            end else begin
                if (line_done) begin
                    chk("done_expected", 32'(outstanding > 0), 32'd1);
                    chk("done_one_cycle", 32'(prev_done), 32'd0);
                    if (outstanding > 0) outstanding--;
                    n_done++;
                    done_cyc = cyc;
                end
                prev_done = line_done;
                chk("line_ready", 32'(line_ready), 32'(outstanding == 0));
                if (mem_wvalid) chk("no_wvalid_during_req", 32'(mem_req), 32'd0);

                if (prev_req_wait) begin
                    chk("req_hold", 32'(mem_req), 32'd1);
                    chk("addr_hold", mem_addr, prev_addr);
                end
                if (mem_req) begin
                    req_len++;
                    if (mem_addr_ok) begin
                        chk("addr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                        if (exp_addr_q.size() != 0) begin
                            ea = exp_addr_q.pop_front();
                            chk("mem_addr", mem_addr, ea);
                        end
                        last_req_len = req_len;
                        req_len = 0;
                        beats_fired = 0;
                    end
                end
                prev_req_wait = mem_req && !mem_addr_ok;
                prev_addr     = mem_addr;

                if (prev_stall) begin
                    chk("stall_wvalid", 32'(mem_wvalid), 32'd1);
                    chk("stall_wdata", mem_wdata, prev_wdata);
                    chk("stall_cnt", 32'(cnt), 32'(prev_cnt));
                end
                if (mem_wvalid && mem_wready) begin
                    chk("beat_expected", 32'(exp_beats.size() != 0), 32'd1);
                    if (exp_beats.size() != 0) begin
                        b = exp_beats.pop_front();
                        chk("wdata", mem_wdata, b.d);
                        chk("wlast", 32'(mem_wlast), 32'(b.last));
                        chk("cnt_at_beat", 32'(cnt), 32'(b.idx));
                    end
                    beats_fired++;
                end
                prev_stall = mem_wvalid && !mem_wready;
                prev_wdata = mem_wdata;
                prev_cnt   = cnt;
            end
        end
    end

    // Offer a line and wait for it to be taken; leaves line_valid high.
    task automatic send_line(input logic [31:0] a, input logic [32*BEATS-1:0] d,
                             output int acc_cyc, output bit done_at_acc);
        bit got = 0;
        line_addr  = a;
        line_data  = d;
        line_valid = 1;
        acc_cyc    = 0;
        done_at_acc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (line_ready) begin
                got = 1;
                break;
            end
        end
        chk("accept_in_time", 32'(got), 32'd1);
        if (!got) begin
            $display("FAIL accept_timeout: line never accepted");
            $fatal(1, "bench aborted");
        end
        acc_cyc     = cyc;
        done_at_acc = line_done;
        @(posedge clk);
        push_exp(a, d);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (outstanding == 0) begin
                ok = 1;
                break;
            end
        end
        chk("idle_in_time", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [32*BEATS-1:0] d;
        int  acc, acc2, nd0;
        bit  dflag;

        resetn = 0; line_valid = 0; line_addr = '0; line_data = '0;
        #2;
        chk("rst_line_ready", 32'(line_ready), 32'd1);
        chk("rst_line_done", 32'(line_done), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wlast", 32'(mem_wlast), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        @(posedge clk); #1;

        // Directed line, zero wait states
        for (int k = 0; k < BEATS; k++) d[32*k +: 32] = 32'h1111_1111 * 32'(k + 1);
        send_line(32'h1FC0_0024, d, acc, dflag);
        line_valid = 0;
        wait_idle();
        chk("latency", 32'(done_cyc - acc), 32'd11);
        chk("beats_sc1", 32'(beats_fired), 32'(BEATS));
        chk("addr_len_sc1", 32'(last_req_len), 32'd1);

        // Address acceptance delayed by 3 cycles
        addr_wait = 3;
        for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom;
        send_line(32'h0000_1234, d, acc, dflag);
        line_valid = 0;
        wait_idle();
        chk("req_len_sc2", 32'(last_req_len), 32'd4);
        addr_wait = 0;

        // Write stalls on beats 2 and 6
        stall_en = 1;
        for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom;
        send_line(32'hABCD_EF7F, d, acc, dflag);
        line_valid = 0;
        wait_idle();
        chk("beats_sc3", 32'(beats_fired), 32'(BEATS));
        chk("cnt_end_sc3", 32'(cnt), 32'd7);
        stall_en = 0;

        // Back-to-back lines with line_valid held across line_done
        for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom;
        send_line(32'h0000_0040, d, acc, dflag);
        for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom;
        send_line(32'h0000_0080, d, acc2, dflag);
        chk("b2b_done_at_accept", 32'(dflag), 32'd1);
        @(negedge clk);
        chk("b2b_req_next", 32'(mem_req), 32'd1);
        line_valid = 0;
        wait_idle();

        // Reset in the middle of beat 4
        for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom;
        send_line(32'h2000_0000, d, acc, dflag);
        line_valid = 0;
        acc2 = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (beats_fired == 4) begin
                acc2 = 1;
                break;
            end
        end
        chk("reach_beat4", 32'(acc2), 32'd1);
        #1 chk("cnt_beat4", 32'(cnt), 32'd4);
        nd0 = n_done;
        #1 resetn = 0;
        #1;
        chk("mid_rst_wvalid", 32'(mem_wvalid), 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_wlast", 32'(mem_wlast), 32'd0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_ready", 32'(line_ready), 32'd1);
        exp_beats.delete();
        exp_addr_q.delete();
        outstanding = 0;
        @(posedge clk); #1;
        for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom;
        line_addr = 32'h3000_0010; line_data = d; line_valid = 1;
        @(negedge clk); #1 resetn = 1;
        @(posedge clk);
        push_exp(32'h3000_0010, d);
        #1 line_valid = 0;
        @(negedge clk);
        chk("post_rst_req", 32'(mem_req), 32'd1);
        wait_idle();
        chk("post_rst_one_done", 32'(n_done - nd0), 32'd1);
        chk("post_rst_beats", 32'(beats_fired), 32'(BEATS));

        // Stray handshake pulses while idle and while in the address phase
        stray_en = 1;
        nd0 = n_done;
        repeat (20) @(posedge clk);
        #1 chk("stray_no_done", 32'(n_done), 32'(nd0));
        chk("stray_idle_req", 32'(mem_req), 32'd0);
        addr_wait = 2;
        for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom;
        send_line(32'h4444_4444, d, acc, dflag);
        line_valid = 0;
        wait_idle();
        chk("stray_req_len", 32'(last_req_len), 32'd3);
        chk("stray_one_done", 32'(n_done - nd0), 32'd1);
        stray_en = 0;
        addr_wait = 0;

        // Randomized traffic
        rand_mode = 1;
        for (int n = 0; n < 15; n++) begin
            for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom;
            send_line($urandom, d, acc, dflag);
            if ($urandom_range(0, 1) == 1) begin
                line_valid = 0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        line_valid = 0;
        wait_idle();
        rand_mode = 0;

        chk("left_beats", 32'(exp_beats.size()), 32'd0);
        chk("left_addrs", 32'(exp_addr_q.size()), 32'd0);
        chk("left_outstanding", 32'(outstanding), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/d_burst_wb.md
D_BURST_WB -- requirements
Module: d_burst_wb

Interface
REQ-001 The block SHALL have parameter BEATS, default 8, meaning words per cache line (legal: 2, 4, 8, 16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port line_valid, input, 1, meaning cache offers a dirty line for write-back.
REQ-005 The block SHALL have port line_addr, input, 32, meaning line base address.
REQ-006 The block SHALL have port line_data, input, 32*BEATS, meaning line contents; word k at bits [32k+31:32k].
REQ-007 The block SHALL have port line_ready, output, 1, meaning the block accepts a line this cycle.
REQ-008 The block SHALL have port line_done, output, 1, meaning a one-cycle pulse when write-back completes.
REQ-009 The block SHALL have port mem_req, output, 1, meaning the burst address request is valid.
REQ-010 The block SHALL have port mem_addr, output, 32, meaning burst base address.
REQ-011 The block SHALL have port mem_addr_ok, input, 1, meaning the address is accepted.
REQ-012 The block SHALL have port mem_wvalid, output, 1, meaning a write beat is valid.
REQ-013 The block SHALL have port mem_wdata, output, 32, meaning beat data.
REQ-014 The block SHALL have port mem_wlast, output, 1, meaning the final beat.
REQ-015 The block SHALL have port mem_wready, input, 1, meaning the beat is accepted.
REQ-016 The block SHALL have port mem_bvalid, input, 1, meaning the write response arrived.
REQ-017 The block SHALL have port cnt, output, 4, meaning the current beat index (debug).

Function
REQ-018 The FSM SHALL have states IDLE, ADDR, DATA and RESP.
REQ-019 In IDLE, line_ready=1 and line_ready SHALL be 0 in every other state.
REQ-020 In IDLE with line_valid=1, the block SHALL capture line_data into the line buffer and capture {line_addr[31:5], 5'b0} (low log2(4*BEATS) bits forced 0) into the address register, then go to ADDR.
REQ-021 In ADDR, mem_req=1 and mem_addr=captured address; on mem_addr_ok=1 the block SHALL set cnt<=0 and go to DATA.
REQ-022 mem_req, mem_addr and the buffer SHALL hold stable while the block waits for mem_addr_ok.
REQ-023 In DATA, mem_wvalid=1 and mem_wdata=buffer word cnt, and mem_wlast=1 iff cnt==BEATS-1.
REQ-024 In DATA with mem_wready=1 and cnt<BEATS-1, the block SHALL set cnt<=cnt+1.
REQ-025 In DATA with mem_wready=1 and cnt==BEATS-1, the block SHALL go to RESP; cnt SHALL NOT wrap past BEATS-1.
REQ-026 With mem_wready=0, the beat SHALL be held unchanged (no skip, no duplicate).
REQ-027 In RESP, the block SHALL wait for mem_bvalid=1, then go to IDLE with line_done registered high for exactly the next cycle.
REQ-028 mem_bvalid, mem_addr_ok and mem_wready SHALL be ignored outside RESP, ADDR and DATA respectively.
REQ-029 A new line SHALL be acceptable in the same cycle line_done is high (IDLE), giving back-to-back bursts.
REQ-030 line_valid is level-sensitive; a line SHALL be taken only on a cycle where line_valid and line_ready are both 1.
REQ-031 Minimum latency SHALL be 1 (accept) + 1 (addr) + BEATS (data) + 1 (resp) cycles to line_done with zero wait states.

Reset
REQ-032 When resetn=0, the block SHALL asynchronously enter IDLE and set cnt=0, line_done=0, mem_req=0, mem_wvalid=0, mem_wlast=0, mem_addr=0, mem_wdata=0, the buffer to 0 and the address register to 0.
REQ-033 Reset mid-burst SHALL abort the burst with no line_done; after release, the block SHALL accept a new line in the first clk edge.

Verification
REQ-034 The bench SHALL cover this scenario: line_valid with addr 0x1FC0_0024, words 0x11111111..0x88888888, all handshakes immediate -> mem_addr=0x1FC0_0020, beats in order word0..word7, wlast on beat 8 only, line_done 11 cycles after accept.
REQ-035 The bench SHALL cover this scenario: mem_addr_ok delayed 3 cycles -> mem_req and mem_addr held 4 cycles, no mem_wvalid before acceptance.
REQ-036 The bench SHALL cover this scenario: mem_wready deasserted on beats 2 and 6 for 2 cycles each -> each word emitted exactly once, 8 accepted beats, cnt ends at 7.
REQ-037 The bench SHALL cover this scenario: line_valid held high across line_done -> second line accepted the cycle line_done=1, mem_req the next cycle.
REQ-038 The bench SHALL cover this scenario: resetn low during beat 4 -> outputs zero immediately, no line_done, next line processed normally from beat 0.
REQ-039 The bench SHALL cover this scenario: stray mem_bvalid and mem_wready pulses in IDLE/ADDR -> no state change, no line_done.
